ddr3_mcb_burst_seq: RTL and testbench
=====================================

# ddr3_mcb_burst_seq

MCB-side data-phase sequencer for the DDR3 controller. Accepts one burst command at a time and produces the MCB data-handshake signals that the AXI-facing read/write data path consumes: `ddr3_mcb_wdat_req` and `ddr3_mcb_rdat_vld`/`ddr3_mcb_rdat`. Write beats are forwarded to the PHY. Read beats from the PHY are buffered and replayed as one contiguous 4-beat burst, because the AXI data path assembles a 256-bit word only from back-to-back valid beats.

## Interface
Parameters:
- `MCB_D_W`, 64: MCB data beat width.
- `MCB_BE_W`, 8: byte-enable width; always `MCB_D_W/8`.
- `BURST_BEATS`, 4: beats per burst; fixed at 4 for this design.

Ports:
- `ddr3_mcb_clk`, in, 1: the single clock; all logic on its rising edge.
- `ddr3_mcb_rst_n`, in, 1: reset, asynchronous, active-low.
- `cmd_vld`, in, 1: burst command valid.
- `cmd_rd`, in, 1: 1 = read burst, 0 = write burst; qualified by `cmd_vld`.
- `cmd_rdy`, out, 1: sequencer is idle and accepts a command.
- `ddr3_mcb_wdat_req`, out, 1: requests one write beat per cycle.
- `ddr3_mcb_wdat`, in, `MCB_D_W`: write beat, valid the cycle after `ddr3_mcb_wdat_req`.
- `ddr3_mcb_wbe`, in, `MCB_BE_W`: byte enables for that beat.
- `ddr3_mcb_rdat_vld`, out, 1: read beat valid.
- `ddr3_mcb_rdat`, out, `MCB_D_W`: read beat.
- `phy_wdat_vld`, out, 1: write beat to the PHY is valid.
- `phy_wdat`, out, `MCB_D_W`: write beat to the PHY.
- `phy_wbe`, out, `MCB_BE_W`: byte enables to the PHY.
- `phy_rd_en`, out, 1: one-cycle pulse requesting a read burst from the PHY.
- `phy_rdat_vld`, in, 1: PHY read beat valid; beats may arrive with gaps.
- `phy_rdat`, in, `MCB_D_W`: PHY read beat.
- `burst_done`, out, 1: one-cycle pulse on the final cycle of a burst.
- `rd_err`, out, 1: sticky flag for an unexpected PHY read beat; cleared only by reset.

## Operation
- States:
  - IDLE
  - WREQ: 4 cycles
  - WDRAIN: 2 cycles
  - RFILL: waits for PHY data
  - RSEND: 4 cycles
- `cmd_rdy` = (state == IDLE). A command is accepted when `cmd_vld && cmd_rdy`.
- Accepted write command: go to WREQ.
  - `ddr3_mcb_wdat_req` is high in every WREQ cycle; a beat counter selects beat 0..3.
  - One-cycle delayed request = sample enable; `ddr3_mcb_wdat`/`ddr3_mcb_wbe` are registered into `phy_wdat`/`phy_wbe` with `phy_wdat_vld`.
  - After 4 WREQ cycles go to WDRAIN. After 2 WDRAIN cycles go to IDLE.
- Accepted read command: go to RFILL.
  - `phy_rd_en` pulses in the first RFILL cycle.
  - Each `phy_rdat_vld` beat writes `buf[fill_cnt]`; `fill_cnt` increments.
  - The edge that stores the 4th beat moves the state to RSEND.
  - In RSEND, `ddr3_mcb_rdat_vld` is high for exactly 4 consecutive cycles, with `ddr3_mcb_rdat = buf[0..3]` in order. Then go to IDLE.
- `ddr3_mcb_rdat` is 0 whenever `ddr3_mcb_rdat_vld` = 0.
- `phy_rdat_vld` in IDLE, WREQ, WDRAIN or RSEND: the beat is discarded and `rd_err` is set.
- `cmd_vld` while busy is ignored; there is no queueing.
- Beat and fill counters are 3 bits and are cleared on entry to WREQ and RFILL; no wrap is possible.
- Reset values (all outputs 0 except `cmd_rdy`):
  - `cmd_rdy` = 1 once reset is released, since the state is IDLE.
  - `ddr3_mcb_wdat_req`, `ddr3_mcb_rdat_vld`, `ddr3_mcb_rdat`, `phy_wdat_vld`, `phy_wdat`, `phy_wbe`, `phy_rd_en`, `burst_done`, `rd_err` = 0.
  - The buffer contents are not reset.
- Reset asserted mid-burst aborts immediately. No partial beats are emitted after reset is released.

## Timing
Command accepted at the rising edge ending cycle T.

Write burst:
- `ddr3_mcb_wdat_req` high T+1..T+4.
- Input beats sampled T+2..T+5.
- `phy_wdat_vld` high T+3..T+6.
- `burst_done` at T+6; `cmd_rdy` high at T+7.

Read burst:
- `phy_rd_en` at T+1.
- If the 4th PHY beat is sampled in cycle R, then `ddr3_mcb_rdat_vld` is high R+1..R+4, `burst_done` at R+4, `cmd_rdy` at R+5.
- Minimum latency: beats at T+2..T+5 give `ddr3_mcb_rdat_vld` at T+6..T+9.

Back-to-back: the next command can be accepted in the first cycle `cmd_rdy` is high.

## Structure
- Shared package `ddr3_mcb_pkg` holds:
  - `MCB_D_W`, `MCB_BE_W`, `BURST_BEATS`;
  - the state encoding (IDLE=0, WREQ=1, WDRAIN=2, RFILL=3, RSEND=4; 3 bits).
- One sub-module, `mcb_burst_buf`: a 4-entry `MCB_D_W` register array with a write port (`we`, `waddr`) and a read address. It has no reset.
- FSM, counters and output registers stay in the top module.

## Test plan
- Reset release: check all outputs at their reset values and `cmd_rdy` = 1.
- Write burst, `cmd_rd`=0:
  - Stimulus: return beats 64'h11.., 22.., 33.., 44.., with wbe FF, 0F, F0, 00, one cycle after each `ddr3_mcb_wdat_req`.
  - Required: `phy_wdat`/`phy_wbe` match in order at T+3..T+6; `burst_done` at T+6.
- Read burst with gapped PHY data:
  - Stimulus: beats A, B, C, D on cycles T+2, T+4, T+5, T+9.
  - Required: `ddr3_mcb_rdat_vld` at T+10..T+13 carrying A, B, C, D; `ddr3_mcb_rdat` = 0 outside those cycles; `rd_err` = 0.
- Stray `phy_rdat_vld` in IDLE: `rd_err` goes to 1 and stays 1; no `ddr3_mcb_rdat_vld`. A following read burst still works.
- `cmd_vld` held high through a write burst: exactly one burst is run; the second command is accepted at T+7; `phy_rd_en` at T+8 if `cmd_rd`=1.
- Reset asserted in RSEND after 2 beats: outputs go to 0 immediately; after release no `ddr3_mcb_rdat_vld`, and `cmd_rdy` = 1.

Source files
------------

// File: rtl/ddr3_mcb_pkg.sv
// Purpose: shared widths and FSM state encoding for the DDR3 MCB burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr3_mcb_pkg;

  localparam int MCB_D_W     = 64;
  localparam int MCB_BE_W    = MCB_D_W / 8;
  localparam int BURST_BEATS = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WREQ   = 3'd1,
    ST_WDRAIN = 3'd2,
    ST_RFILL  = 3'd3,
    ST_RSEND  = 3'd4
  } mcb_state_e;

endpackage

// File: rtl/mcb_burst_buf.sv
// Purpose: 4-entry read-beat buffer, one write port and one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller owns all sequencing. No reset on the storage.
// Ports: we/waddr/wdata store one beat; raddr selects rdata combinationally.
module mcb_burst_buf #(
  parameter int MCB_D_W = 64
) (
  input  logic               ddr3_mcb_clk,
  input  logic               we,
  input  logic [2:0]         waddr,
  input  logic [MCB_D_W-1:0] wdata,
  input  logic [2:0]         raddr,
  output logic [MCB_D_W-1:0] rdata
);

  logic [MCB_D_W-1:0] mem [4];

  // Counters are 3 bits wide; an out-of-range address never writes and reads 0.
  always_ff @(posedge ddr3_mcb_clk) begin
    if (we && !waddr[2]) begin
      mem[waddr[1:0]] <= wdata;
    end
  end

  assign rdata = raddr[2] ? '0 : mem[raddr[1:0]];

endmodule

// File: rtl/ddr3_mcb_burst_seq.sv
// Purpose: MCB data-phase sequencer; forwards 4 write beats to the PHY, buffers 4 PHY read beats and replays them contiguously.
// Latency: write: req T+1..T+4, PHY beats T+3..T+6; read: replay starts the cycle after the 4th PHY beat is stored.
// Backpressure: single command in flight; cmd_rdy only in IDLE, commands while busy are ignored.
// Ports: cmd_* command handshake; ddr3_mcb_wdat_req/wdat/wbe write-beat pull; ddr3_mcb_rdat_vld/rdat read replay;
//        phy_* PHY write beats, read request and read beats; burst_done final-cycle pulse; rd_err sticky stray-beat flag.
module ddr3_mcb_burst_seq #(
  parameter int MCB_D_W     = ddr3_mcb_pkg::MCB_D_W,
  parameter int MCB_BE_W    = ddr3_mcb_pkg::MCB_BE_W,
  parameter int BURST_BEATS = ddr3_mcb_pkg::BURST_BEATS
) (
  input  logic                ddr3_mcb_clk,
  input  logic                ddr3_mcb_rst_n,
  input  logic                cmd_vld,
  input  logic                cmd_rd,
  output logic                cmd_rdy,
  output logic                ddr3_mcb_wdat_req,
  input  logic [MCB_D_W-1:0]  ddr3_mcb_wdat,
  input  logic [MCB_BE_W-1:0] ddr3_mcb_wbe,
  output logic                ddr3_mcb_rdat_vld,
  output logic [MCB_D_W-1:0]  ddr3_mcb_rdat,
  output logic                phy_wdat_vld,
  output logic [MCB_D_W-1:0]  phy_wdat,
  output logic [MCB_BE_W-1:0] phy_wbe,
  output logic                phy_rd_en,
  input  logic                phy_rdat_vld,
  input  logic [MCB_D_W-1:0]  phy_rdat,
  output logic                burst_done,
  output logic                rd_err
);

  import ddr3_mcb_pkg::*;

  localparam logic [2:0] LAST_BEAT  = 3'(BURST_BEATS - 1);
  localparam logic [2:0] LAST_DRAIN = 3'd1;

  mcb_state_e         state_q;
  mcb_state_e         state_d;
  logic [2:0]         beat_cnt;   // WREQ / WDRAIN / RSEND cycle index
  logic [2:0]         fill_cnt;   // PHY read beats stored so far
  logic               wreq_d;     // delayed request = write-beat sample enable
  logic               accept;
  logic               buf_we;
  logic               stray_beat;
  logic [MCB_D_W-1:0] buf_rdata;

  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    cmd_rdy           = 1'b0;
    ddr3_mcb_wdat_req = 1'b0;
    ddr3_mcb_rdat_vld = 1'b0;
    ddr3_mcb_rdat     = '0;
    burst_done        = 1'b0;
    buf_we            = 1'b0;
    stray_beat        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy    = 1'b1;
        stray_beat = phy_rdat_vld;
        if (cmd_vld) begin
          accept  = 1'b1;
          state_d = cmd_rd ? ST_RFILL : ST_WREQ;
        end
      end
      ST_WREQ: begin
        ddr3_mcb_wdat_req = 1'b1;
        stray_beat        = phy_rdat_vld;
        if (beat_cnt == LAST_BEAT) state_d = ST_WDRAIN;
      end
      ST_WDRAIN: begin
        stray_beat = phy_rdat_vld;
        if (beat_cnt == LAST_DRAIN) begin
          burst_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_RFILL: begin
        buf_we = phy_rdat_vld;
        if (phy_rdat_vld && fill_cnt == LAST_BEAT) state_d = ST_RSEND;
      end
      ST_RSEND: begin
        ddr3_mcb_rdat_vld = 1'b1;
        ddr3_mcb_rdat     = buf_rdata;
        stray_beat        = phy_rdat_vld;
        if (beat_cnt == LAST_BEAT) begin
          burst_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
    if (!ddr3_mcb_rst_n) begin
      state_q      <= ST_IDLE;
      beat_cnt     <= '0;
      fill_cnt     <= '0;
      wreq_d       <= 1'b0;
      phy_wdat_vld <= 1'b0;
      phy_wdat     <= '0;
      phy_wbe      <= '0;
      phy_rd_en    <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      state_q <= state_d;
      // Restart the per-state cycle index on every state change.
      if (state_d != state_q) begin
        beat_cnt <= '0;
      end else if (state_q != ST_IDLE && state_q != ST_RFILL) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
      if (accept) begin
        fill_cnt <= '0;
      end else if (buf_we) begin
        fill_cnt <= fill_cnt + 3'd1;
      end
      wreq_d       <= ddr3_mcb_wdat_req;
      phy_wdat_vld <= wreq_d;
      phy_wdat     <= wreq_d ? ddr3_mcb_wdat : '0;
      phy_wbe      <= wreq_d ? ddr3_mcb_wbe : '0;
      phy_rd_en    <= accept && cmd_rd;
      if (stray_beat) rd_err <= 1'b1;
    end
  end

  mcb_burst_buf #(
    .MCB_D_W (MCB_D_W)
  ) u_buf (
    .ddr3_mcb_clk (ddr3_mcb_clk),
    .we           (buf_we),
    .waddr        (fill_cnt),
    .wdata        (phy_rdat),
    .raddr        (beat_cnt),
    .rdata        (buf_rdata)
  );

endmodule

// File: tb/tb_ddr3_mcb_burst_seq.sv
// Purpose: self-checking bench for ddr3_mcb_burst_seq with directed and randomized bursts.
// Latency: expected cycle windows derived from the command cycle T and the 4th PHY beat cycle.
// Backpressure: exercises held cmd_vld, gapped PHY beats, stray beats and mid-burst reset.
module tb_ddr3_mcb_burst_seq;

  logic        ddr3_mcb_clk = 1'b0;
  logic        ddr3_mcb_rst_n;
  logic        cmd_vld, cmd_rd, cmd_rdy;
  logic        ddr3_mcb_wdat_req;
  logic [63:0] ddr3_mcb_wdat;
  logic [7:0]  ddr3_mcb_wbe;
  logic        ddr3_mcb_rdat_vld;
  logic [63:0] ddr3_mcb_rdat;
  logic        phy_wdat_vld;
  logic [63:0] phy_wdat;
  logic [7:0]  phy_wbe;
  logic        phy_rd_en;
  logic        phy_rdat_vld;
  logic [63:0] phy_rdat;
  logic        burst_done;
  logic        rd_err;

  always #5 ddr3_mcb_clk = ~ddr3_mcb_clk;

  ddr3_mcb_burst_seq dut (
    .ddr3_mcb_clk      (ddr3_mcb_clk),
    .ddr3_mcb_rst_n    (ddr3_mcb_rst_n),
    .cmd_vld           (cmd_vld),
    .cmd_rd            (cmd_rd),
    .cmd_rdy           (cmd_rdy),
    .ddr3_mcb_wdat_req (ddr3_mcb_wdat_req),
    .ddr3_mcb_wdat     (ddr3_mcb_wdat),
    .ddr3_mcb_wbe      (ddr3_mcb_wbe),
    .ddr3_mcb_rdat_vld (ddr3_mcb_rdat_vld),
    .ddr3_mcb_rdat     (ddr3_mcb_rdat),
    .phy_wdat_vld      (phy_wdat_vld),
    .phy_wdat          (phy_wdat),
    .phy_wbe           (phy_wbe),
    .phy_rd_en         (phy_rd_en),
    .phy_rdat_vld      (phy_rdat_vld),
    .phy_rdat          (phy_rdat),
    .burst_done        (burst_done),
    .rd_err            (rd_err)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic        err_exp  = 1'b0;   // model of the sticky error flag
  logic [63:0] wd [4];            // write beats returned to the sequencer
  logic [7:0]  wb [4];
  logic [63:0] rb [4];            // PHY read beats, in arrival order
  int          off [4];           // PHY beat cycles relative to the command cycle

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ddr3_mcb_clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_wdat_req"},  ddr3_mcb_wdat_req, 0);
    chk({pfx, "_rdat_vld"},  ddr3_mcb_rdat_vld, 0);
    chk({pfx, "_rdat"},      ddr3_mcb_rdat, 0);
    chk({pfx, "_phy_vld"},   phy_wdat_vld, 0);
    chk({pfx, "_phy_wdat"},  phy_wdat, 0);
    chk({pfx, "_phy_wbe"},   phy_wbe, 0);
    chk({pfx, "_phy_rd_en"}, phy_rd_en, 0);
    chk({pfx, "_done"},      burst_done, 0);
    chk({pfx, "_rd_err"},    rd_err, 0);
  endtask

  task automatic rand_write_data();
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      wb[i] = 8'($urandom);
    end
  endtask

  task automatic rand_read_data();
    for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
    off[0] = 2 + $urandom_range(0, 2);
    for (int i = 1; i < 4; i++) off[i] = off[i-1] + 1 + $urandom_range(0, 3);
  endtask

  // Called in the command cycle T; returns in cycle T+7 (first cycle ready again).
  // With hold set, cmd_vld stays high and a read command is left presented.
  task automatic do_write(input bit hold);
    chk("w_cmd_rdy_T", cmd_rdy, 1);
    cmd_vld = 1'b1;
    cmd_rd  = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) begin
        if (hold) cmd_rd = 1'b1;
        else cmd_vld = 1'b0;
      end
      if (c >= 2 && c <= 5) begin
        ddr3_mcb_wdat = wd[c-2];
        ddr3_mcb_wbe  = wb[c-2];
      end else begin
        ddr3_mcb_wdat = '0;
        ddr3_mcb_wbe  = '0;
      end
      chk("w_req", ddr3_mcb_wdat_req, (c >= 1 && c <= 4));
      chk("w_phy_vld", phy_wdat_vld, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        chk("w_phy_wdat", phy_wdat, wd[c-3]);
        chk("w_phy_wbe", phy_wbe, wb[c-3]);
      end
      chk("w_done", burst_done, (c == 6));
      chk("w_cmd_rdy", cmd_rdy, (c == 7));
      chk("w_phy_rd_en", phy_rd_en, 0);
      chk("w_rdat_vld", ddr3_mcb_rdat_vld, 0);
      chk("w_rd_err", rd_err, err_exp);
    end
  endtask

  // Called in the command cycle T; PHY beats rb[i] arrive at T+off[i].
  // abort_c != 0 asserts reset in cycle T+abort_c and checks the aftermath.
  task automatic do_read(input int abort_c);
    int last;
    int sidx;
    last = off[3];
    chk("r_cmd_rdy_T", cmd_rdy, 1);
    cmd_vld = 1'b1;
    cmd_rd  = 1'b1;
    for (int c = 1; c <= last + 5; c++) begin
      step();
      if (c == 1) cmd_vld = 1'b0;
      if (abort_c != 0 && c == abort_c) begin
        ddr3_mcb_rst_n = 1'b0;
        err_exp        = 1'b0;
        #1;
        chk_zero_outputs("abort");
        step();
        step();
        ddr3_mcb_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
          step();
          chk("post_rst_rdat_vld", ddr3_mcb_rdat_vld, 0);
          chk("post_rst_rdat", ddr3_mcb_rdat, 0);
          chk("post_rst_cmd_rdy", cmd_rdy, 1);
          chk("post_rst_done", burst_done, 0);
        end
        return;
      end
      phy_rdat_vld = 1'b0;
      phy_rdat     = '0;
      for (int i = 0; i < 4; i++) begin
        if (off[i] == c) begin
          phy_rdat_vld = 1'b1;
          phy_rdat     = rb[i];
        end
      end
      sidx = c - last - 1;
      chk("r_phy_rd_en", phy_rd_en, (c == 1));
      chk("r_rdat_vld", ddr3_mcb_rdat_vld, (sidx >= 0 && sidx <= 3));
      chk("r_rdat", ddr3_mcb_rdat, (sidx >= 0 && sidx <= 3) ? rb[sidx] : 64'h0);
      chk("r_done", burst_done, (c == last + 4));
      chk("r_cmd_rdy", cmd_rdy, (c == last + 5));
      chk("r_wdat_req", ddr3_mcb_wdat_req, 0);
      chk("r_rd_err", rd_err, err_exp);
    end
  endtask

  initial begin
    ddr3_mcb_rst_n = 1'b0;
    cmd_vld        = 1'b0;
    cmd_rd         = 1'b0;
    ddr3_mcb_wdat  = '0;
    ddr3_mcb_wbe   = '0;
    phy_rdat_vld   = 1'b0;
    phy_rdat       = '0;

    // Reset state.
    repeat (3) step();
    chk_zero_outputs("in_rst");
    ddr3_mcb_rst_n = 1'b1;
    step();
    chk_zero_outputs("rst_rel");
    chk("rst_rel_cmd_rdy", cmd_rdy, 1);

    // Directed write burst.
    wd[0] = 64'h1111_1111_1111_1111; wb[0] = 8'hFF;
    wd[1] = 64'h2222_2222_2222_2222; wb[1] = 8'h0F;
    wd[2] = 64'h3333_3333_3333_3333; wb[2] = 8'hF0;
    wd[3] = 64'h4444_4444_4444_4444; wb[3] = 8'h00;
    do_write(1'b0);

    // Directed gapped read: beats at T+2, T+4, T+5, T+9.
    for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
    off[0] = 2; off[1] = 4; off[2] = 5; off[3] = 9;
    do_read(0);

    // Randomized mix of back-to-back bursts.
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        rand_read_data();
        do_read(0);
      end else begin
        rand_write_data();
        do_write(1'b0);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // Stray PHY beat while idle sets the sticky error; reads still work.
    phy_rdat_vld = 1'b1;
    phy_rdat     = {$urandom, $urandom};
    step();
    phy_rdat_vld = 1'b0;
    phy_rdat     = '0;
    err_exp      = 1'b1;
    chk("stray_rd_err", rd_err, 1);
    chk("stray_rdat_vld", ddr3_mcb_rdat_vld, 0);
    step();
    chk("stray_rd_err_sticky", rd_err, 1);
    chk("stray_rdat_vld2", ddr3_mcb_rdat_vld, 0);
    rand_read_data();
    do_read(0);

    // cmd_vld held through a write: one write, then the read accepted at T+7.
    rand_write_data();
    rand_read_data();
    do_write(1'b1);
    do_read(0);

    // Reset during replay, after two beats have gone out.
    for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
    off[0] = 2; off[1] = 3; off[2] = 4; off[3] = 5;
    do_read(off[3] + 3);

    // Sequencer still runs a normal write after the abort.
    rand_write_data();
    do_write(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
